// File: rtl/serial_ram_ctrl_if.sv
// rtl/serial_ram_ctrl_if.sv - serial frame bus between host and serial_ram_ctrl
interface serial_ram_ctrl_if;
    logic ss_n;
    logic mosi;
    logic miso;
    logic miso_valid;
    logic frame_err;

    modport master (
        output ss_n,
        output mosi,
        input  miso,
        input  miso_valid,
        input  frame_err
    );

    modport slave (
        input  ss_n,
        input  mosi,
        output miso,
        output miso_valid,
        output frame_err
    );
endinterface

// File: rtl/serial_ram_ctrl.sv
// rtl/serial_ram_ctrl.sv - bit-serial command decoder in front of a small RAM
module serial_ram_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    serial_ram_ctrl_if.slave  bus
);
    // One shift register serves both payload capture and read-out.
    localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = $clog2(SW + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CMD     = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd2;
    localparam logic [2:0] READ    = 3'd3;
    localparam logic [2:0] SEND    = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [31:0]           DEPTH32   = 32'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [2:0]            state_q, state_d;
    logic [1:0]            cmd_q, cmd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         shift_q, shift_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  miso_q, miso_d;
    logic                  miso_valid_q, miso_valid_d;
    logic                  frame_err_q, frame_err_d;

    logic                  mem_we;
    logic [SW-1:0]         shift_in;
    logic [CW-1:0]         need;

    // Addresses arriving on the wire may exceed the RAM; fold them back in.
    function automatic logic [ADDR_WIDTH-1:0] reduce_addr(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] w;
        w = 32'(a) % DEPTH32;
        return w[ADDR_WIDTH-1:0];
    endfunction

    // Post-access address step, wrapping at the last implemented word.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    assign bus.miso       = miso_q;
    assign bus.miso_valid = miso_valid_q;
    assign bus.frame_err  = frame_err_q;

    // Frame decoder; ss_n high in the middle of a frame aborts it.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        miso_d       = 1'b0;
        miso_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        mem_we       = 1'b0;
        shift_in     = {shift_q[SW-2:0], bus.mosi};
        need         = (cmd_q == 2'b01) ? CW'(DATA_WIDTH) : CW'(ADDR_WIDTH);

        if (bus.ss_n && (state_q == CMD || state_q == PAYLOAD ||
                         state_q == READ || state_q == SEND)) begin
            state_d     = IDLE;
            cnt_d       = '0;
            frame_err_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.ss_n) begin
                        cmd_d   = {bus.mosi, 1'b0};
                        cnt_d   = '0;
                        state_d = CMD;
                    end
                end
                CMD: begin
                    cmd_d   = {cmd_q[1], bus.mosi};
                    cnt_d   = '0;
                    state_d = (cmd_q[1] && bus.mosi) ? READ : PAYLOAD;
                end
                PAYLOAD: begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == need - CW'(1)) begin
                        case (cmd_q)
                            2'b00:   wr_addr_d = reduce_addr(shift_in[ADDR_WIDTH-1:0]);
                            2'b10:   rd_addr_d = reduce_addr(shift_in[ADDR_WIDTH-1:0]);
                            2'b01: begin
                                mem_we    = 1'b1;
                                wr_addr_d = next_addr(wr_addr_q);
                            end
                            default: ;
                        endcase
                        state_d = DONE;
                    end
                end
                READ: begin
                    shift_d = SW'(mem[rd_addr_q]);
                    cnt_d   = '0;
                    state_d = SEND;
                end
                SEND: begin
                    if (cnt_q < CW'(DATA_WIDTH)) begin
                        miso_d       = shift_q[DATA_WIDTH-1];
                        miso_valid_d = 1'b1;
                        shift_d      = {shift_q[SW-2:0], 1'b0};
                        cnt_d        = cnt_q + CW'(1);
                    end else begin
                        rd_addr_d = next_addr(rd_addr_q);
                        cnt_d     = '0;
                        state_d   = DONE;
                    end
                end
                DONE: begin
                    if (bus.ss_n) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control and output registers; reset leaves the RAM untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            cnt_q        <= '0;
            shift_q      <= '0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            miso_q       <= 1'b0;
            miso_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            miso_q       <= miso_d;
            miso_valid_q <= miso_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // RAM write port, fed straight from the bit that completes the word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr_q] <= shift_in[DATA_WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_serial_ram_ctrl.sv
// tb/tb_serial_ram_ctrl.sv - frame-level model bench for serial_ram_ctrl
module tb_serial_ram_ctrl;
    logic clk;
    logic rst;

    serial_ram_ctrl_if bus0();
    serial_ram_ctrl_if bus1();

    serial_ram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256)) dut (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    serial_ram_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .MEM_DEPTH(12)) dut2 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: per-instance geometry, RAM image and address registers.
    int          aw    [2] = '{8, 4};
    int          dw    [2] = '{8, 16};
    int          depth [2] = '{256, 12};
    logic [15:0] mm    [2][256];
    int          mwr   [2];
    int          mrd   [2];

    // Expected outputs after the most recent rising edge.
    logic e_miso  [2];
    logic e_valid [2];
    logic e_err   [2];

    logic [15:0] got;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle output check for both instances.
    always @(negedge clk) begin
        chk("miso0",  32'(bus0.miso),       32'(e_miso[0]));
        chk("valid0", 32'(bus0.miso_valid), 32'(e_valid[0]));
        chk("err0",   32'(bus0.frame_err),  32'(e_err[0]));
        chk("miso1",  32'(bus1.miso),       32'(e_miso[1]));
        chk("valid1", 32'(bus1.miso_valid), 32'(e_valid[1]));
        chk("err1",   32'(bus1.frame_err),  32'(e_err[1]));
    end

    // Drive one edge on instance s (the other idles) and record what must follow it.
    task automatic tick(input int s, input logic ss, input logic m,
                        input logic em, input logic ev, input logic ee);
        if (s == 0) begin
            bus0.ss_n = ss; bus0.mosi = m; bus1.ss_n = 1'b1; bus1.mosi = 1'b0;
        end else begin
            bus1.ss_n = ss; bus1.mosi = m; bus0.ss_n = 1'b1; bus0.mosi = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int j = 0; j < 2; j++) begin
            e_miso[j]  = (j == s) ? em : 1'b0;
            e_valid[j] = (j == s) ? ev : 1'b0;
            e_err[j]   = (j == s) ? ee : 1'b0;
        end
    endtask

    task automatic chk_regs(input int s, input string tag);
        chk({tag, "_wr"}, (s == 0) ? 32'(dut.wr_addr_q) : 32'(dut2.wr_addr_q), 32'(mwr[s]));
        chk({tag, "_rd"}, (s == 0) ? 32'(dut.rd_addr_q) : 32'(dut2.rd_addr_q), 32'(mrd[s]));
    endtask

    // One complete frame; abort_bits>=0 raises ss_n after that many payload bits,
    // rst_bit>=0 asserts reset just after that read bit appears.
    task automatic do_frame(input int s, input logic [1:0] cmd, input logic [15:0] pay,
                            input int abort_bits, input int rst_bit, output logic [15:0] word);
        int          n;
        logic [15:0] v;
        logic [15:0] data;
        word = '0;
        tick(s, 1'b0, cmd[1], 1'b0, 1'b0, 1'b0);
        tick(s, 1'b0, cmd[0], 1'b0, 1'b0, 1'b0);
        if (cmd == 2'b11) begin
            data = mm[s][mrd[s]];
            tick(s, 1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < dw[s]; k++) begin
                tick(s, 1'b0, 1'($urandom), data[dw[s]-1-k], 1'b1, 1'b0);
                word = {word[14:0], (s == 0) ? bus0.miso : bus1.miso};
                if (k == rst_bit) begin
                    #1;
                    rst = 1'b0;
                    for (int j = 0; j < 2; j++) begin
                        e_miso[j] = 1'b0; e_valid[j] = 1'b0; e_err[j] = 1'b0;
                        mwr[j] = 0; mrd[j] = 0;
                    end
                    #1;
                    chk("rst_now_miso",  32'(bus0.miso),       32'd0);
                    chk("rst_now_valid", 32'(bus0.miso_valid), 32'd0);
                    chk("rst_now_rd",    32'(dut.rd_addr_q),   32'd0);
                    repeat (3) tick(s, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                    rst = 1'b1;
                    tick(s, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                    return;
                end
            end
            tick(s, 1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
            mrd[s] = (mrd[s] + 1) % depth[s];
        end else begin
            n = (cmd == 2'b01) ? dw[s] : aw[s];
            for (int i = 0; i < n; i++) begin
                if (i == abort_bits) begin
                    tick(s, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
                    tick(s, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                    return;
                end
                tick(s, 1'b0, pay[n-1-i], 1'b0, 1'b0, 1'b0);
            end
            v = pay & 16'((32'd1 << n) - 1);
            case (cmd)
                2'b00: mwr[s] = int'(v) % depth[s];
                2'b10: mrd[s] = int'(v) % depth[s];
                default: begin
                    mm[s][mwr[s]] = v;
                    mwr[s] = (mwr[s] + 1) % depth[s];
                end
            endcase
        end
        tick(s, 1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
        tick(s, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        bus0.ss_n = 1'b1; bus0.mosi = 1'b0;
        bus1.ss_n = 1'b1; bus1.mosi = 1'b0;
        for (int j = 0; j < 2; j++) begin
            e_miso[j] = 1'b0; e_valid[j] = 1'b0; e_err[j] = 1'b0;
            mwr[j] = 0; mrd[j] = 0;
            for (int a = 0; a < 256; a++) mm[j][a] = '0;
        end

        repeat (5) tick(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_state", 32'(dut.state_q), 32'd0);
        chk_regs(0, "reset");
        chk("reset_shift", 32'(dut.shift_q), 32'd0);
        rst = 1'b1;
        tick(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Write with wrap at the top of the RAM.
        do_frame(0, 2'b00, 16'h00FF, -1, -1, got);
        do_frame(0, 2'b01, 16'h0001, -1, -1, got);
        chk("wrap_mem_ff", 32'(dut.mem[8'hFF]), 32'h01);
        chk("wrap_wr",     32'(dut.wr_addr_q), 32'h00);
        chk_regs(0, "wrap");

        // Write increment.
        do_frame(0, 2'b00, 16'h0010, -1, -1, got);
        do_frame(0, 2'b01, 16'h00A5, -1, -1, got);
        do_frame(0, 2'b01, 16'h005A, -1, -1, got);
        chk("inc_mem_10", 32'(dut.mem[8'h10]), 32'hA5);
        chk("inc_mem_11", 32'(dut.mem[8'h11]), 32'h5A);
        chk("inc_wr",     32'(dut.wr_addr_q), 32'h12);
        chk("model_pin",  32'(mm[0][8'h11]),  32'h5A);

        // Read back two consecutive words.
        do_frame(0, 2'b10, 16'h0010, -1, -1, got);
        do_frame(0, 2'b11, 16'h0000, -1, -1, got);
        chk("read_word0", 32'(got), 32'hA5);
        chk("read_rd0",   32'(dut.rd_addr_q), 32'h11);
        do_frame(0, 2'b11, 16'h0000, -1, -1, got);
        chk("read_word1", 32'(got), 32'h5A);
        chk_regs(0, "read");

        // Abort mid-payload leaves RAM and pointer alone.
        do_frame(0, 2'b01, 16'h0077, -1, -1, got);
        do_frame(0, 2'b00, 16'h0012, -1, -1, got);
        do_frame(0, 2'b01, 16'h00FF, 5, -1, got);
        chk("abort_mem", 32'(dut.mem[8'h12]), 32'h77);
        chk("abort_wr",  32'(dut.wr_addr_q), 32'h12);
        chk("abort_state", 32'(dut.state_q), 32'd0);
        do_frame(0, 2'b10, 16'h0033, 3, -1, got);
        do_frame(0, 2'b00, 16'h0044, 0, -1, got);
        chk_regs(0, "abort");

        // Reset during the fourth read bit.
        do_frame(0, 2'b10, 16'h0010, -1, -1, got);
        do_frame(0, 2'b11, 16'h0000, -1, 3, got);
        chk("rst_mem_10", 32'(dut.mem[8'h10]), 32'hA5);
        chk("rst_mem_ff", 32'(dut.mem[8'hFF]), 32'h01);
        chk_regs(0, "rst");
        do_frame(0, 2'b10, 16'h00FF, -1, -1, got);
        do_frame(0, 2'b11, 16'h0000, -1, -1, got);
        chk("post_rst_word", 32'(got), 32'h01);
        chk("post_rst_rd",   32'(dut.rd_addr_q), 32'h00);

        // Narrow-address, wide-data, non-power-of-two depth instance.
        do_frame(1, 2'b00, 16'h000B, -1, -1, got);
        do_frame(1, 2'b01, 16'hBEEF, -1, -1, got);
        chk("p_wr_wrap", 32'(dut2.wr_addr_q), 32'h0);
        do_frame(1, 2'b01, 16'h1234, -1, -1, got);
        chk("p_mem_0",   32'(dut2.mem[0]), 32'h1234);
        chk("p_mem_11",  32'(dut2.mem[11]), 32'hBEEF);
        do_frame(1, 2'b10, 16'h000B, -1, -1, got);
        do_frame(1, 2'b11, 16'h0000, -1, -1, got);
        chk("p_read", 32'(got), 32'hBEEF);
        chk("p_rd_wrap", 32'(dut2.rd_addr_q), 32'h0);
        do_frame(1, 2'b00, 16'h000E, -1, -1, got);
        chk("p_mod_wr", 32'(dut2.wr_addr_q), 32'h2);
        chk_regs(1, "param");

        repeat (2) tick(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
